// File: rtl/debug_cmd_sync_if.sv
// Consumer-side command bus of debug_cmd_sync: FIFO head, pop handshake and status.
// The master modport is the synchroniser/FIFO; the slave modport is the consumer.
interface debug_cmd_sync_if #(
    parameter int SR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int FIFO_DEPTH = 4
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [SR_WIDTH-1:0]           jdo;
    logic [IR_WIDTH-1:0]           cmd_ir;
    logic [(2**IR_WIDTH)-1:0]      take_action;
    logic                          ir_update;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          clr_overflow;

    modport master (
        output cmd_valid, jdo, cmd_ir, take_action, ir_update, fifo_level, overflow,
        input  cmd_ready, clr_overflow
    );

    modport slave (
        input  cmd_valid, jdo, cmd_ir, take_action, ir_update, fifo_level, overflow,
        output cmd_ready, clr_overflow
    );
endinterface

// File: rtl/debug_cmd_sync.sv
// Brings JTAG update-DR/update-IR levels into the clk domain, turns each rising edge
// into one event, and buffers {ir, payload} commands in a small first-word fall-through FIFO.
module debug_cmd_sync #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vs_udr,
    input  logic                vs_uir,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [SR_WIDTH-1:0] sr,
    debug_cmd_sync_if.master    cmd
);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW   = AW + 1;
    localparam int EW   = IR_WIDTH + SR_WIDTH;
    localparam int NCMD = 2 ** IR_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic                   udr_evt;
    logic                   uir_evt;

    logic                   push_q;
    logic [EW-1:0]          push_data_q;
    logic                   uir_evt_q;
    logic                   ir_update_q;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic                   overflow_q;

    logic                   full;
    logic                   valid;
    logic                   pop;
    logic                   do_push;
    logic                   drop;
    logic [EW-1:0]          head;
    logic [NCMD-1:0]        take_action;

    assign udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_hist;

    assign full    = (level == FULL_LEVEL);
    assign valid   = (level != '0) & ~reset;
    assign pop     = valid & cmd.cmd_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push_q & (~full | pop);
    assign drop    = push_q & full & ~pop;
    assign head    = mem[rd_ptr];

    always_comb begin
        take_action = '0;
        if (pop) begin
            take_action[head[EW-1:SR_WIDTH]] = 1'b1;
        end
    end

    assign cmd.cmd_valid   = valid;
    assign cmd.jdo         = valid ? head[SR_WIDTH-1:0] : '0;
    assign cmd.cmd_ir      = valid ? head[EW-1:SR_WIDTH] : '0;
    assign cmd.take_action = take_action;
    assign cmd.ir_update   = ir_update_q & ~reset;
    assign cmd.fifo_level  = reset ? '0 : level;
    assign cmd.overflow    = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync    <= '0;
            uir_sync    <= '0;
            udr_hist    <= 1'b0;
            uir_hist    <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            uir_evt_q   <= 1'b0;
            ir_update_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            udr_sync    <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync    <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist    <= udr_sync[SYNC_STAGES-1];
            uir_hist    <= uir_sync[SYNC_STAGES-1];
            // The command word is captured in the detect cycle and written one edge later.
            push_q      <= udr_evt;
            if (udr_evt) begin
                push_data_q <= {ir_in, sr};
            end
            uir_evt_q   <= uir_evt;
            ir_update_q <= uir_evt_q;

            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (cmd.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_data_q;
        end
    end
endmodule

// File: tb/tb_debug_cmd_sync.sv
// Directed bench for debug_cmd_sync: latency, pop decoding, overflow, wrap, edge-only
// events and reset behaviour, each against hand-computed values.
module tb_debug_cmd_sync;
    localparam int SR_WIDTH    = 38;
    localparam int IR_WIDTH    = 2;
    localparam int SYNC_STAGES = 3;
    localparam int FIFO_DEPTH  = 4;

    logic                clk;
    logic                reset;
    logic                vs_udr;
    logic                vs_uir;
    logic [IR_WIDTH-1:0] ir_in;
    logic [SR_WIDTH-1:0] sr;

    int checks;
    int fails;

    debug_cmd_sync_if #(
        .SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_if ();

    debug_cmd_sync #(
        .SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH),
        .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vs_udr(vs_udr),
        .vs_uir(vs_uir),
        .ir_in(ir_in),
        .sr(sr),
        .cmd(dut_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One udr pulse long enough to be seen, then a gap so the next one is a fresh edge.
    task automatic applyStimulus(input logic [IR_WIDTH-1:0] ir, input logic [SR_WIDTH-1:0] data);
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic popExpect(input string tag, input logic [SR_WIDTH-1:0] data, input logic [IR_WIDTH-1:0] ir);
        logic [3:0] onehot;
        onehot = 4'b0001 << ir;
        checkOutput({tag, "_valid"}, 64'(dut_if.cmd_valid), 64'd1);
        checkOutput({tag, "_jdo"}, 64'(dut_if.jdo), 64'(data));
        checkOutput({tag, "_ir"}, 64'(dut_if.cmd_ir), 64'(ir));
        dut_if.cmd_ready = 1'b1;
        #1;
        checkOutput({tag, "_action"}, 64'(dut_if.take_action), 64'(onehot));
        tick();
        dut_if.cmd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ir_pulses;
        int first_pulse;
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        ir_in  = '0;
        sr     = '0;
        dut_if.cmd_ready    = 1'b0;
        dut_if.clr_overflow = 1'b0;

        repeat (2) tick();
        checkOutput("rst_valid", 64'(dut_if.cmd_valid), 64'd0);
        checkOutput("rst_level", 64'(dut_if.fifo_level), 64'd0);
        checkOutput("rst_ovf", 64'(dut_if.overflow), 64'd0);
        checkOutput("rst_action", 64'(dut_if.take_action), 64'd0);
        checkOutput("rst_irupd", 64'(dut_if.ir_update), 64'd0);
        reset = 1'b0;
        tick();

        // Latency: valid after the 5th edge counting the one that first samples vs_udr.
        ir_in  = 2'd2;
        sr     = 38'h2A_DEADBEEF;
        vs_udr = 1'b1;
        repeat (4) tick();
        checkOutput("lat_early", 64'(dut_if.cmd_valid), 64'd0);
        tick();
        checkOutput("lat_valid", 64'(dut_if.cmd_valid), 64'd1);
        checkOutput("lat_level", 64'(dut_if.fifo_level), 64'd1);
        vs_udr = 1'b0;
        popExpect("first", 38'h2A_DEADBEEF, 2'd2);
        checkOutput("first_after_valid", 64'(dut_if.cmd_valid), 64'd0);
        checkOutput("first_after_action", 64'(dut_if.take_action), 64'd0);
        checkOutput("first_after_level", 64'(dut_if.fifo_level), 64'd0);

        // Long uir level: one ir_update pulse, same latency, no FIFO write.
        vs_uir      = 1'b1;
        ir_pulses   = 0;
        first_pulse = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (dut_if.ir_update) begin
                ir_pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
        end
        vs_uir = 1'b0;
        checkOutput("uir_pulses", 64'(ir_pulses), 64'd1);
        checkOutput("uir_latency", 64'(first_pulse), 64'd5);
        checkOutput("uir_level", 64'(dut_if.fifo_level), 64'd0);

        // Long udr level: exactly one push.
        ir_in  = 2'd1;
        sr     = 38'h11;
        vs_udr = 1'b1;
        repeat (20) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
        checkOutput("udr_hold_level", 64'(dut_if.fifo_level), 64'd1);
        popExpect("udr_hold", 38'h11, 2'd1);

        // Five commands into a depth-4 FIFO: the fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(IR_WIDTH'(i), SR_WIDTH'(i));
        end
        checkOutput("ovf_level", 64'(dut_if.fifo_level), 64'd4);
        checkOutput("ovf_flag", 64'(dut_if.overflow), 64'd1);
        popExpect("ovf_pop1", 38'd1, 2'd1);
        popExpect("ovf_pop2", 38'd2, 2'd2);
        popExpect("ovf_pop3", 38'd3, 2'd3);
        popExpect("ovf_pop4", 38'd4, 2'd0);
        checkOutput("ovf_empty", 64'(dut_if.cmd_valid), 64'd0);

        // Cmd_ready on an empty FIFO does nothing.
        dut_if.cmd_ready = 1'b1;
        #1;
        checkOutput("idle_ready_action", 64'(dut_if.take_action), 64'd0);
        tick();
        dut_if.cmd_ready = 1'b0;
        checkOutput("idle_ready_level", 64'(dut_if.fifo_level), 64'd0);

        // Clear coinciding with a drop: set wins; a lone clear then takes effect.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(IR_WIDTH'(i), SR_WIDTH'(8'h10 + i));
        end
        ir_in  = 2'd0;
        sr     = 38'h14;
        vs_udr = 1'b1;
        repeat (4) tick();
        dut_if.clr_overflow = 1'b1;
        tick();
        dut_if.clr_overflow = 1'b0;
        vs_udr = 1'b0;
        checkOutput("clr_drop_ovf", 64'(dut_if.overflow), 64'd1);
        checkOutput("clr_drop_level", 64'(dut_if.fifo_level), 64'd4);
        dut_if.clr_overflow = 1'b1;
        tick();
        dut_if.clr_overflow = 1'b0;
        checkOutput("clr_alone_ovf", 64'(dut_if.overflow), 64'd0);
        repeat (2) tick();

        // Full FIFO, push coinciding with a pop: both happen, no overflow.
        ir_in  = 2'd1;
        sr     = 38'h15;
        vs_udr = 1'b1;
        repeat (4) tick();
        popExpect("full_pp_pop", 38'h10, 2'd0);
        vs_udr = 1'b0;
        checkOutput("full_pp_level", 64'(dut_if.fifo_level), 64'd4);
        checkOutput("full_pp_ovf", 64'(dut_if.overflow), 64'd0);
        repeat (3) tick();
        popExpect("wrap_pop1", 38'h11, 2'd1);
        popExpect("wrap_pop2", 38'h12, 2'd2);
        popExpect("wrap_pop3", 38'h13, 2'd3);
        popExpect("wrap_pop4", 38'h15, 2'd1);
        checkOutput("wrap_empty", 64'(dut_if.fifo_level), 64'd0);

        // Mid-operation reset with vs_udr held high through release.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd3, SR_WIDTH'(8'h20 + i));
        end
        checkOutput("pre_rst_level", 64'(dut_if.fifo_level), 64'd4);
        checkOutput("pre_rst_ovf", 64'(dut_if.overflow), 64'd1);
        ir_in  = 2'd3;
        sr     = 38'h30;
        vs_udr = 1'b1;
        reset  = 1'b1;
        dut_if.cmd_ready = 1'b1;
        #1;
        checkOutput("in_rst_valid", 64'(dut_if.cmd_valid), 64'd0);
        checkOutput("in_rst_jdo", 64'(dut_if.jdo), 64'd0);
        checkOutput("in_rst_action", 64'(dut_if.take_action), 64'd0);
        tick();
        reset = 1'b0;
        dut_if.cmd_ready = 1'b0;
        checkOutput("post_rst_level", 64'(dut_if.fifo_level), 64'd0);
        checkOutput("post_rst_ovf", 64'(dut_if.overflow), 64'd0);
        repeat (4) tick();
        checkOutput("post_rst_early", 64'(dut_if.fifo_level), 64'd0);
        tick();
        checkOutput("post_rst_one", 64'(dut_if.fifo_level), 64'd1);
        repeat (10) tick();
        checkOutput("post_rst_still_one", 64'(dut_if.fifo_level), 64'd1);
        vs_udr = 1'b0;
        popExpect("post_rst_pop", 38'h30, 2'd3);
        checkOutput("post_rst_empty", 64'(dut_if.cmd_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/debug_cmd_sync.md
DEBUG_CMD_SYNC -- requirements
Module: debug_cmd_sync

Interface
REQ-001 SHALL have parameter SR_WIDTH, default 38: width of the debug shift-register payload.
REQ-002 SHALL have parameter IR_WIDTH, default 2: width of the instruction register; there are 2**IR_WIDTH command types.
REQ-003 SHALL have parameter SYNC_STAGES, default 3, minimum 2: depth of the synchroniser flop chain.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2: number of buffered commands.
REQ-005 Ports SHALL be as follows; the block uses one clock, and reset is synchronous and active-high:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- vs_udr  in  1  update-DR level from the JTAG domain; asynchronous.
- vs_uir  in  1  update-IR level from the JTAG domain; asynchronous.
- ir_in  in  IR_WIDTH  instruction; quasi-static while vs_udr/vs_uir are high.
- sr  in  SR_WIDTH  shift-register payload; quasi-static while vs_udr is high.
- cmd_ready  in  1  consumer accepts the head command.
- clr_overflow  in  1  clears the overflow flag.
- cmd_valid  out  1  FIFO non-empty.
- jdo  out  SR_WIDTH  head command payload.
- cmd_ir  out  IR_WIDTH  head command instruction.
- take_action  out  2**IR_WIDTH  one-hot pulse on command pop.
- ir_update  out  1  one-cycle pulse per update-IR event.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a command is dropped.

Function
REQ-006 vs_udr and vs_uir SHALL each pass through a SYNC_STAGES-deep flop chain, followed by one history flop; an event is the rising edge detected between the last stage and the history flop.
REQ-007 On a udr event, {ir_in, sr} SHALL be written into the FIFO at the next clk edge; ir_in and sr are sampled in the cycle the event is detected.
REQ-008 From an empty FIFO, cmd_valid SHALL assert at the (SYNC_STAGES+2)th clk edge after the first edge that samples vs_udr high.
REQ-009 A uir event SHALL pulse ir_update for exactly one cycle, with the same latency as REQ-008; a uir event SHALL NOT write the FIFO.
REQ-010 An event SHALL fire once per input rising edge, regardless of how long the level stays high.
REQ-011 cmd_valid SHALL be 1 exactly when fifo_level is nonzero; jdo and cmd_ir SHALL present the oldest entry, first-word fall-through.
REQ-012 A pop SHALL occur in a cycle when cmd_valid and cmd_ready are both 1; in that same cycle take_action[cmd_ir] SHALL be 1 and all other take_action bits 0.
REQ-013 take_action SHALL be all-zero in any cycle without a pop.
REQ-014 Push with fifo_level < FIFO_DEPTH: the entry SHALL be stored and fifo_level SHALL increment by 1.
REQ-015 Push with the FIFO full and no pop: the entry SHALL be dropped, overflow SHALL be set, and fifo_level SHALL stay at FIFO_DEPTH.
REQ-016 Simultaneous push and pop: both SHALL occur and fifo_level SHALL be unchanged; this includes the full case, with no overflow raised.
REQ-017 Simultaneous push and pop on an empty FIFO cannot occur; cmd_valid is 0, so no pop happens.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated entry.
REQ-019 clr_overflow SHALL clear overflow at the next edge; if a drop occurs in the same cycle, set SHALL win.
REQ-020 cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-021 jdo and cmd_ir are defined only while cmd_valid=1.

Reset
REQ-022 While reset is high, every synchroniser flop, history flop, pointer, fifo_level and overflow SHALL clear to 0 at each clk edge.
REQ-023 During reset, cmd_valid, take_action, ir_update, jdo and cmd_ir SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered commands.
REQ-025 A vs_udr held high through the release of reset SHALL produce exactly one command after release, because the history flop resets to 0.

Verification
REQ-026 With SR_WIDTH=38, IR_WIDTH=2, SYNC_STAGES=3: ir_in=2, sr=0x2A_DEADBEEF, vs_udr pulse, cmd_ready=1 -> cmd_valid high 5 edges after sampling, jdo=0x2ADEADBEEF, cmd_ir=2, take_action=4'b0100 for one cycle.
REQ-027 FIFO_DEPTH=4, cmd_ready=0, 5 udr events with sr=1..5 -> fifo_level=4, overflow=1; then cmd_ready=1 -> pops sr=1,2,3,4 in order, and 5 is lost.
REQ-028 FIFO full, udr event coincident with a pop -> fifo_level stays 4, overflow stays 0, and the new entry is the last one out.
REQ-029 vs_uir held high for 20 cycles -> ir_update high for exactly 1 cycle and fifo_level unchanged; vs_udr held 20 cycles -> exactly 1 push.
REQ-030 3 entries buffered, reset for 1 cycle with vs_udr held high -> fifo_level=0 and overflow=0 after reset, then exactly 1 new command appears.
REQ-031 overflow=1 with clr_overflow coincident with a drop -> overflow remains 1; clr_overflow alone on the next cycle -> overflow=0.
